memory_bus_bridge: RTL and testbench
====================================

# memory_bus_bridge

Bridges the core's single-outstanding memory handshake (`memory_enable`/`memory_command` in; `memory_ready`/`memory_valid` out) to a request/acknowledge word bus with variable wait states. It sits directly downstream of the instruction controller and serves both instruction fetch and load/store.

Per access it:
- latches the request;
- holds it on the bus until acknowledged or timed out;
- returns read data with a one-cycle valid pulse.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum `REQUEST` cycles before an access is aborted. 0 disables the timeout. Valid range 0..65535.

Ports:
- `clk`  input  1  clock; all state changes on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `memory_enable`  input  1  request strobe from the controller; honoured only while `memory_ready`=1
- `memory_command`  input  1  0 = read, 1 = write; sampled with `memory_enable`
- `memory_address`  input  32  byte address; bits [1:0] ignored
- `memory_write_data`  input  32  write data, lane-aligned
- `memory_byte_enable`  input  4  write lane mask from the store encoder; ignored for reads
- `memory_ready`  output  1  bridge idle, can accept a request this cycle
- `memory_valid`  output  1  one-cycle pulse: access complete
- `memory_read_data`  output  32  read result; stable from the `memory_valid` cycle until the next read completes
- `memory_error`  output  1  qualifies `memory_valid`: access failed (bus error or timeout)
- `bus_request`  output  1  access pending on the bus
- `bus_write`  output  1  1 = write cycle
- `bus_address`  output  32  word address `{memory_address[31:2], 2'b00}`
- `bus_write_data`  output  32  latched write data
- `bus_byte_enable`  output  4  latched lanes; 4'b1111 for reads
- `bus_acknowledge`  input  1  slave completes the access this cycle
- `bus_error`  input  1  meaningful only with `bus_acknowledge`
- `bus_read_data`  input  32  valid with `bus_acknowledge` on reads

## Operation

Three-state FSM.

- **`IDLE`**
  - `memory_ready`=1.
  - On `memory_enable`=1, latch command, address, write data and byte enable into the bus registers.
  - Clear the wait counter and go to `REQUEST`.
- **`REQUEST`**
  - `bus_request`=1; all `bus_*` outputs held constant.
  - `memory_ready`=0; `memory_enable` is ignored.
  - On `bus_acknowledge`=1:
    - read: capture `bus_read_data` into `memory_read_data`;
    - write: leave `memory_read_data` unchanged;
    - set `memory_error`=`bus_error`; on error, load `memory_read_data` with 0;
    - go to `RESPOND`.
  - Otherwise, when `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`-1: set `memory_error`=1, load `memory_read_data` with 0, go to `RESPOND`.
  - Otherwise increment the counter, which is 16 bits and saturating.
- **`RESPOND`**
  - `memory_valid`=1 and `memory_ready`=0, so a controller that re-asserts enable while it consumes valid cannot launch a duplicate access.
  - Next state is always `IDLE`.
- `memory_error` is driven to 1 only in `RESPOND` and cleared on leaving it.
- `bus_acknowledge` and `bus_error` outside `REQUEST` are ignored.
- `memory_enable` and `memory_command` outside `IDLE` are ignored.

Reset (`reset`=0, asynchronous):
- state `IDLE`, so `memory_ready`=1 once reset deasserts;
- `memory_valid`=0, `memory_error`=0, `memory_read_data`=0;
- `bus_request`=0, `bus_write`=0, `bus_address`=0, `bus_write_data`=0, `bus_byte_enable`=0, counter=0.

Reset mid-access:
- `bus_request` drops immediately, without waiting for a clock;
- no `memory_valid` is produced;
- a late `bus_acknowledge` after reset is ignored.

## Timing

- All outputs are registered, or decoded from state only; there is no combinational input-to-output path.
- Acceptance: `memory_enable` sampled at edge N (in `IDLE`) → `bus_request`=1 from cycle N+1.
- Ack at edge N+k (k≥1, first possible k=1) → `memory_valid`=1 during cycle N+k+1 → `memory_ready`=1 from cycle N+k+2.
- Minimum enable-to-valid: 2 cycles. Minimum back-to-back period: 3 cycles per access.
- Timeout: with no ack, `bus_request` is high for exactly `TIMEOUT_CYCLES` cycles, then `RESPOND`.
- Ack and timeout in the same cycle: the ack wins, and `memory_error` follows `bus_error`.

## Test plan

- **Read, 1 wait state:** enable, command=0, address=32'h0000_1006 → `bus_address`=32'h0000_1004, `bus_byte_enable`=4'b1111. Ack on the 2nd `REQUEST` cycle with data 32'hDEAD_BEEF → `memory_valid` one cycle with `memory_read_data`=32'hDEAD_BEEF, `memory_error`=0; `memory_ready` returns the following cycle.
- **Zero-wait write plus held enable:** command=1, data 32'h1234_5678, byte enable 4'b1100, ack in the 1st `REQUEST` cycle, `memory_enable` held high throughout → bus fields match; `memory_valid` exactly 2 cycles after acceptance; exactly one bus access; `memory_read_data` unchanged; second acceptance only in the cycle `memory_ready`=1.
- **Timeout:** `TIMEOUT_CYCLES`=4, no ack → `bus_request` high exactly 4 cycles, then `memory_valid`=1 with `memory_error`=1 and `memory_read_data`=0. A later ack is ignored.
- **Bus error:** read acknowledged with `bus_error`=1 and data 32'hFFFF_FFFF → `memory_error`=1, `memory_read_data`=0.
- **Reset mid-request:** assert `reset`=0 between edges during `REQUEST` → `bus_request` low before the next edge. After release, `memory_ready`=1 and no `memory_valid` pulse occurs.
- **Ack/timeout collision:** `TIMEOUT_CYCLES`=3, ack on the 3rd cycle with `bus_error`=0 → `memory_error`=0 and data captured.

Source files
------------

// File: rtl/memory_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : memory_bus_bridge
// Purpose  : Converts the core's single-outstanding memory handshake
//            (memory_enable/memory_command in, memory_ready/memory_valid out)
//            into a request/acknowledge word bus with variable wait states.
//            Each access is latched, held on the bus until acknowledged or
//            timed out, and completed with a one-cycle memory_valid pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES  maximum REQUEST cycles before abort (0 = no timeout),
//                   valid range 0..65535
// Ports
//   clk                 in   clock, rising edge
//   reset               in   asynchronous active-low reset
//   memory_enable       in   request strobe, honoured only while ready
//   memory_command      in   0 = read, 1 = write
//   memory_address      in   byte address, bits [1:0] ignored
//   memory_write_data   in   lane-aligned write data
//   memory_byte_enable  in   write lane mask (ignored on reads)
//   memory_ready        out  bridge idle, can accept a request
//   memory_valid        out  one-cycle completion pulse
//   memory_read_data    out  read result, held until the next read completes
//   memory_error        out  qualifies memory_valid: bus error or timeout
//   bus_request         out  access pending on the bus
//   bus_write           out  1 = write cycle
//   bus_address         out  word-aligned address
//   bus_write_data      out  latched write data
//   bus_byte_enable     out  latched lanes, 4'b1111 for reads
//   bus_acknowledge     in   slave completes the access this cycle
//   bus_error           in   error flag, meaningful with bus_acknowledge
//   bus_read_data       in   read data, valid with bus_acknowledge
// ============================================================================
module memory_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_data,
  input  logic [3:0]  memory_byte_enable,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] memory_read_data,
  output logic        memory_error,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  input  logic        bus_acknowledge,
  input  logic        bus_error,
  input  logic [31:0] bus_read_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  // Timeout fires while the counter holds the value TIMEOUT_CYCLES-1, which
  // keeps bus_request high for exactly TIMEOUT_CYCLES cycles.
  localparam logic        C_TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] C_TIMEOUT_LAST =
    (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic        ready_q;
  logic        valid_q;
  logic        error_q;
  logic [31:0] rdata_q;
  logic        req_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Byte offset bits never reach the word bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^memory_address[1:0];

  // Saturating wait counter, so a disabled timeout never wraps.
  assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= 32'd0;
      req_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      cnt_q   <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          error_q <= 1'b0;
          if (memory_enable) begin
            write_q <= memory_command;
            addr_q  <= {memory_address[31:2], 2'b00};
            wdata_q <= memory_write_data;
            be_q    <= memory_command ? memory_byte_enable : 4'b1111;
            cnt_q   <= 16'd0;
            req_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_REQUEST;
          end
        end

        S_REQUEST: begin
          // Acknowledge is checked first so it wins over a same-cycle timeout.
          if (bus_acknowledge) begin
            if (bus_error) begin
              rdata_q <= 32'd0;
            end else if (!write_q) begin
              rdata_q <= bus_read_data;
            end
            error_q <= bus_error;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_RESPOND;
          end else if (C_TIMEOUT_EN && (cnt_q == C_TIMEOUT_LAST)) begin
            rdata_q <= 32'd0;
            error_q <= 1'b1;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_RESPOND;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_RESPOND: begin
          // ready stays low during the valid cycle so a held enable cannot
          // start a second access until the controller has seen completion.
          valid_q <= 1'b0;
          error_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          valid_q <= 1'b0;
          error_q <= 1'b0;
          req_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign memory_ready     = ready_q;
  assign memory_valid     = valid_q;
  assign memory_error     = error_q;
  assign memory_read_data = rdata_q;
  assign bus_request      = req_q;
  assign bus_write        = write_q;
  assign bus_address      = addr_q;
  assign bus_write_data   = wdata_q;
  assign bus_byte_enable  = be_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_bus_bridge
// Purpose  : Directed self-checking bench for memory_bus_bridge. The main
//            instance uses TIMEOUT_CYCLES=4; a second instance with
//            TIMEOUT_CYCLES=3 shares all inputs and is checked for the
//            ack/timeout collision case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_bus_bridge;

  logic        clk;
  logic        reset;
  logic        memory_enable;
  logic        memory_command;
  logic [31:0] memory_address;
  logic [31:0] memory_write_data;
  logic [3:0]  memory_byte_enable;
  logic        bus_acknowledge;
  logic        bus_error;
  logic [31:0] bus_read_data;

  logic        memory_ready;
  logic        memory_valid;
  logic [31:0] memory_read_data;
  logic        memory_error;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;

  logic        c_ready;
  logic        c_valid;
  logic [31:0] c_rdata;
  logic        c_error;
  logic        c_request;
  logic        c_write;
  logic [31:0] c_address;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;

  int checks;
  int errors;

  memory_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .memory_enable      (memory_enable),
    .memory_command     (memory_command),
    .memory_address     (memory_address),
    .memory_write_data  (memory_write_data),
    .memory_byte_enable (memory_byte_enable),
    .memory_ready       (memory_ready),
    .memory_valid       (memory_valid),
    .memory_read_data   (memory_read_data),
    .memory_error       (memory_error),
    .bus_request        (bus_request),
    .bus_write          (bus_write),
    .bus_address        (bus_address),
    .bus_write_data     (bus_write_data),
    .bus_byte_enable    (bus_byte_enable),
    .bus_acknowledge    (bus_acknowledge),
    .bus_error          (bus_error),
    .bus_read_data      (bus_read_data)
  );

  memory_bus_bridge #(.TIMEOUT_CYCLES(3)) dut_c (
    .clk                (clk),
    .reset              (reset),
    .memory_enable      (memory_enable),
    .memory_command     (memory_command),
    .memory_address     (memory_address),
    .memory_write_data  (memory_write_data),
    .memory_byte_enable (memory_byte_enable),
    .memory_ready       (c_ready),
    .memory_valid       (c_valid),
    .memory_read_data   (c_rdata),
    .memory_error       (c_error),
    .bus_request        (c_request),
    .bus_write          (c_write),
    .bus_address        (c_address),
    .bus_write_data     (c_wdata),
    .bus_byte_enable    (c_be),
    .bus_acknowledge    (bus_acknowledge),
    .bus_error          (bus_error),
    .bus_read_data      (bus_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs driven here are
  // sampled at the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    memory_enable = 1'b0;
    memory_command = 1'b0;
    memory_address = 32'd0;
    memory_write_data = 32'd0;
    memory_byte_enable = 4'd0;
    bus_acknowledge = 1'b0;
    bus_error = 1'b0;
    bus_read_data = 32'd0;
    step();
    step();
    checks++;
    if ({memory_ready, memory_valid, memory_error, bus_request, bus_write} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 10000",
               {memory_ready, memory_valid, memory_error, bus_request, bus_write});
    end
    checks++;
    if ({memory_read_data, bus_address, bus_write_data, bus_byte_enable} !== 100'd0) begin
      errors++;
      $display("FAIL reset_data got rd=%h ad=%h wd=%h be=%h expected all zero",
               memory_read_data, bus_address, bus_write_data, bus_byte_enable);
    end
    reset = 1'b1;
    step();
    checks++;
    if (memory_ready !== 1'b1 || bus_request !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b req=%b expected 1 0", memory_ready, bus_request);
    end
  endtask

  task automatic test_read_wait();
    memory_enable = 1'b1;
    memory_command = 1'b0;
    memory_address = 32'h0000_1006;
    memory_write_data = 32'h5555_AAAA;
    memory_byte_enable = 4'b0011;
    step();
    memory_enable = 1'b0;
    // first REQUEST cycle, no ack yet
    checks++;
    if (bus_request !== 1'b1 || bus_write !== 1'b0 || memory_ready !== 1'b0 ||
        bus_address !== 32'h0000_1004 || bus_byte_enable !== 4'b1111) begin
      errors++;
      $display("FAIL read_bus got req=%b wr=%b rdy=%b ad=%h be=%b expected 1 0 0 00001004 1111",
               bus_request, bus_write, memory_ready, bus_address, bus_byte_enable);
    end
    step();
    checks++;
    if (bus_request !== 1'b1 || memory_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_wait got req=%b valid=%b expected 1 0", bus_request, memory_valid);
    end
    bus_acknowledge = 1'b1;
    bus_read_data = 32'hDEAD_BEEF;
    step();
    bus_acknowledge = 1'b0;
    bus_read_data = 32'd0;
    checks++;
    if (memory_valid !== 1'b1 || memory_error !== 1'b0 || memory_read_data !== 32'hDEAD_BEEF ||
        memory_ready !== 1'b0 || bus_request !== 1'b0) begin
      errors++;
      $display("FAIL read_valid got v=%b e=%b rd=%h rdy=%b req=%b expected 1 0 deadbeef 0 0",
               memory_valid, memory_error, memory_read_data, memory_ready, bus_request);
    end
    step();
    checks++;
    if (memory_valid !== 1'b0 || memory_ready !== 1'b1 || memory_read_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_after got v=%b rdy=%b rd=%h expected 0 1 deadbeef",
               memory_valid, memory_ready, memory_read_data);
    end
  endtask

  task automatic test_back_to_back();
    memory_enable = 1'b1;
    memory_command = 1'b1;
    memory_address = 32'h0000_2003;
    memory_write_data = 32'h1234_5678;
    memory_byte_enable = 4'b1100;
    step();
    checks++;
    if (bus_request !== 1'b1 || bus_write !== 1'b1 || bus_address !== 32'h0000_2000 ||
        bus_write_data !== 32'h1234_5678 || bus_byte_enable !== 4'b1100) begin
      errors++;
      $display("FAIL write_bus got req=%b wr=%b ad=%h wd=%h be=%b expected 1 1 00002000 12345678 1100",
               bus_request, bus_write, bus_address, bus_write_data, bus_byte_enable);
    end
    bus_acknowledge = 1'b1;
    bus_read_data = 32'hCAFE_0000;
    step();
    bus_acknowledge = 1'b0;
    checks++;
    if (memory_valid !== 1'b1 || memory_error !== 1'b0 || memory_read_data !== 32'hDEAD_BEEF ||
        memory_ready !== 1'b0 || bus_request !== 1'b0) begin
      errors++;
      $display("FAIL write_valid got v=%b e=%b rd=%h rdy=%b req=%b expected 1 0 deadbeef 0 0",
               memory_valid, memory_error, memory_read_data, memory_ready, bus_request);
    end
    // enable still high through RESPOND: must not relaunch yet
    step();
    checks++;
    if (memory_ready !== 1'b1 || bus_request !== 1'b0 || memory_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_dup got rdy=%b req=%b v=%b expected 1 0 0",
               memory_ready, bus_request, memory_valid);
    end
    step();
    checks++;
    if (bus_request !== 1'b1 || memory_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_second_accept got req=%b rdy=%b expected 1 0", bus_request, memory_ready);
    end
    memory_enable = 1'b0;
    bus_acknowledge = 1'b1;
    step();
    bus_acknowledge = 1'b0;
    bus_read_data = 32'd0;
    step();
    checks++;
    if (memory_ready !== 1'b1 || memory_read_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_end got rdy=%b rd=%h expected 1 deadbeef", memory_ready, memory_read_data);
    end
  endtask

  task automatic test_bus_error();
    memory_enable = 1'b1;
    memory_command = 1'b0;
    memory_address = 32'h0000_4000;
    step();
    memory_enable = 1'b0;
    bus_acknowledge = 1'b1;
    bus_error = 1'b1;
    bus_read_data = 32'hFFFF_FFFF;
    step();
    bus_acknowledge = 1'b0;
    bus_error = 1'b0;
    bus_read_data = 32'd0;
    checks++;
    if (memory_valid !== 1'b1 || memory_error !== 1'b1 || memory_read_data !== 32'd0) begin
      errors++;
      $display("FAIL bus_error got v=%b e=%b rd=%h expected 1 1 00000000",
               memory_valid, memory_error, memory_read_data);
    end
    step();
    checks++;
    if (memory_error !== 1'b0 || memory_valid !== 1'b0 || memory_ready !== 1'b1) begin
      errors++;
      $display("FAIL bus_error_clear got e=%b v=%b rdy=%b expected 0 0 1",
               memory_error, memory_valid, memory_ready);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    // good read first so the zeroing on timeout is visible
    memory_enable = 1'b1;
    memory_command = 1'b0;
    memory_address = 32'h0000_3000;
    step();
    memory_enable = 1'b0;
    bus_acknowledge = 1'b1;
    bus_read_data = 32'h1357_9BDF;
    step();
    bus_acknowledge = 1'b0;
    bus_read_data = 32'd0;
    checks++;
    if (memory_read_data !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL timeout_pre got rd=%h expected 13579bdf", memory_read_data);
    end
    step();
    memory_enable = 1'b1;
    step();
    memory_enable = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_request !== 1'b1) break;
      req_cycles++;
      step();
    end
    checks++;
    if (req_cycles != 4) begin
      errors++;
      $display("FAIL timeout_len got %0d request cycles expected 4", req_cycles);
    end
    checks++;
    if (memory_valid !== 1'b1 || memory_error !== 1'b1 || memory_read_data !== 32'd0) begin
      errors++;
      $display("FAIL timeout_resp got v=%b e=%b rd=%h expected 1 1 00000000",
               memory_valid, memory_error, memory_read_data);
    end
    // a late ack must have no effect
    bus_acknowledge = 1'b1;
    bus_read_data = 32'h7777_7777;
    step();
    step();
    bus_acknowledge = 1'b0;
    bus_read_data = 32'd0;
    checks++;
    if (memory_valid !== 1'b0 || memory_error !== 1'b0 || memory_read_data !== 32'd0 ||
        bus_request !== 1'b0 || memory_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_late_ack got v=%b e=%b rd=%h req=%b rdy=%b expected 0 0 00000000 0 1",
               memory_valid, memory_error, memory_read_data, bus_request, memory_ready);
    end
  endtask

  task automatic test_reset_mid();
    int valid_seen;
    memory_enable = 1'b1;
    memory_command = 1'b1;
    memory_address = 32'h0000_5000;
    memory_write_data = 32'hABCD_EF01;
    memory_byte_enable = 4'b0001;
    step();
    memory_enable = 1'b0;
    checks++;
    if (bus_request !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre got req=%b expected 1", bus_request);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus_request !== 1'b0 || memory_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async got req=%b rdy=%b expected 0 1", bus_request, memory_ready);
    end
    bus_acknowledge = 1'b1;
    step();
    reset = 1'b1;
    step();
    bus_acknowledge = 1'b0;
    valid_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (memory_valid === 1'b1 || bus_request === 1'b1 || memory_ready !== 1'b1) valid_seen++;
      step();
    end
    checks++;
    if (valid_seen != 0) begin
      errors++;
      $display("FAIL reset_mid_after got %0d bad cycles expected 0", valid_seen);
    end
  endtask

  task automatic test_collision();
    memory_enable = 1'b1;
    memory_command = 1'b0;
    memory_address = 32'h0000_6000;
    step();
    memory_enable = 1'b0;
    step();
    step();
    checks++;
    if (c_request !== 1'b1) begin
      errors++;
      $display("FAIL collision_pre got req=%b expected 1", c_request);
    end
    bus_acknowledge = 1'b1;
    bus_error = 1'b0;
    bus_read_data = 32'h0BAD_F00D;
    step();
    bus_acknowledge = 1'b0;
    bus_read_data = 32'd0;
    checks++;
    if (c_valid !== 1'b1 || c_error !== 1'b0 || c_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL collision got v=%b e=%b rd=%h expected 1 0 0badf00d", c_valid, c_error, c_rdata);
    end
    step();
    checks++;
    if (c_ready !== 1'b1 || c_valid !== 1'b0) begin
      errors++;
      $display("FAIL collision_after got rdy=%b v=%b expected 1 0", c_ready, c_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read_wait();
    test_back_to_back();
    test_bus_error();
    test_timeout();
    test_reset_mid();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
